// File: rtl/trace_port_tx.sv
// trace_port_tx
// Transmit end of the parallel trace port. Serialises 128-bit frames into a
// DDR nibble stream on 1, 2 or 4 lanes. Frames are interleaved with full syncs
// (0x7FFFFFFF) and halfword syncs (0x7FFF). Each element is sent LSB-first.
// On every cycle, TraceDouta carries the lower w bits and TraceDoutb the next
// w bits, where w is the number of active lanes. Both outputs feed ODDRX1F
// primitives.
//
// Ports:
//   clkOut      system clock
//   rst         synchronous, active-high reset
//   Enable      transmitter enable
//   Width       lane select: 01=1 lane, 10=2 lanes, 11=4 lanes, 00=1 lane
//   FrameIn     frame to send; byte 0 = FrameIn[7:0] is sent first
//   FrameValid  FrameIn is valid
//   FrameReady  the block accepts FrameIn this cycle
//   TraceDouta  first-edge lane data (registered)
//   TraceDoutb  second-edge lane data (registered)
//   Busy        the state is not IDLE
//   FramesSent  count of fully transmitted frames; wraps at 2^32
//   state_dbg   current FSM state (0=IDLE, 1=FSYNC, 2=HSYNC, 3=FRAME)
//
// Handshake: a frame moves from the source only in a cycle where both
// FrameValid and FrameReady are 1. FrameReady does not depend on FrameValid.
// While no transfer happens, the source may change FrameIn freely.
module trace_port_tx #(
  parameter int MAX_BUS_WIDTH = 4,
  parameter int SYNC_INTERVAL = 16
) (
  input  logic                     clkOut,
  input  logic                     rst,
  input  logic                     Enable,
  input  logic [1:0]               Width,
  input  logic [127:0]             FrameIn,
  input  logic                     FrameValid,
  output logic                     FrameReady,
  output logic [MAX_BUS_WIDTH-1:0] TraceDouta,
  output logic [MAX_BUS_WIDTH-1:0] TraceDoutb,
  output logic                     Busy,
  output logic [31:0]              FramesSent,
  output logic [1:0]               state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, FSYNC = 2'd1, HSYNC = 2'd2, FRAME = 2'd3} state_t;

  localparam logic [127:0] FULL_SYNC = 128'h7FFF_FFFF;
  localparam logic [127:0] HALF_SYNC = 128'h7FFF;

  state_t         state;
  logic [127:0]   shift_q;      // bits of the current element not yet sent
  logic [5:0]     cnt_q;        // cycles left in the element after this one
  logic [1:0]     lw_q;         // log2 of the lanes in use for this element
  logic [7:0]     sync_cnt;
  logic           full_sync_pending;
  logic           enable_d;
  logic [31:0]    frames_q;

  logic           boundary;
  logic           enable_rise;
  logic           sync_due;
  logic [1:0]     lw_next;
  state_t         next_state;
  logic [127:0]   next_elem;
  logic [5:0]     next_cnt;
  logic [3:0]     step_next;
  logic [3:0]     step_cur;

  // Packs one cycle of output as {second edge, first edge}. Lanes above the
  // active width are held at zero.
  function automatic logic [7:0] beat(input logic [7:0] s, input logic [1:0] lw);
    case (lw)
      2'd0:    beat = {3'b000, s[1], 3'b000, s[0]};
      2'd1:    beat = {2'b00, s[3:2], 2'b00, s[1:0]};
      default: beat = s;
    endcase
  endfunction

  // An element is chosen on its own last cycle. That includes every idle
  // cycle, so consecutive elements run back to back with no gap.
  assign boundary    = (state == IDLE) || (cnt_q == 6'd0);
  // A rising Enable counts as a pending full sync in the same cycle, so the
  // first element after enable is always a full sync.
  assign enable_rise = Enable && !enable_d;
  assign sync_due    = full_sync_pending || enable_rise || (sync_cnt == 8'(SYNC_INTERVAL));
  assign FrameReady  = !rst && boundary && Enable && !sync_due;

  assign Busy       = (state != IDLE);
  assign FramesSent = frames_q;
  assign state_dbg  = state;

  always_comb begin
    case (Width)
      2'b10:   lw_next = 2'd1;
      2'b11:   lw_next = 2'd2;
      default: lw_next = 2'd0;
    endcase
  end

  assign step_next = 4'd2 << lw_next;
  assign step_cur  = 4'd2 << lw_q;

  // Chooses the next element. The load values are cycle counts minus one:
  // a frame takes 64, 32 or 16 cycles; a full sync 16, 8 or 4; a halfword
  // sync 8, 4 or 2.
  always_comb begin
    next_state = IDLE;
    next_elem  = '0;
    next_cnt   = '0;
    if (Enable) begin
      if (sync_due) begin
        next_state = FSYNC;
        next_elem  = FULL_SYNC;
        next_cnt   = 6'd15 >> lw_next;
      end else if (FrameValid) begin
        next_state = FRAME;
        next_elem  = FrameIn;
        next_cnt   = 6'd63 >> lw_next;
      end else begin
        next_state = HSYNC;
        next_elem  = HALF_SYNC;
        next_cnt   = 6'd7 >> lw_next;
      end
    end
  end

  always_ff @(posedge clkOut) begin
    if (rst) begin
      state             <= IDLE;
      shift_q           <= '0;
      cnt_q             <= '0;
      lw_q              <= '0;
      sync_cnt          <= '0;
      full_sync_pending <= 1'b1;
      enable_d          <= 1'b0;
      frames_q          <= '0;
      TraceDouta        <= '0;
      TraceDoutb        <= '0;
    end else begin
      enable_d <= Enable;
      // Setting the flag here is overridden below when a full sync starts
      // in this same cycle.
      if (enable_rise)
        full_sync_pending <= 1'b1;
      if (state == FRAME && cnt_q == 6'd0)
        frames_q <= frames_q + 32'd1;

      if (boundary) begin
        state <= next_state;
        lw_q  <= lw_next;
        if (next_state == IDLE) begin
          shift_q    <= '0;
          cnt_q      <= '0;
          TraceDouta <= '0;
          TraceDoutb <= '0;
        end else begin
          // The first beat goes straight to the outputs, so data leaves on
          // the cycle after the element is loaded.
          {TraceDoutb, TraceDouta} <= beat(next_elem[7:0], lw_next);
          shift_q                  <= next_elem >> step_next;
          cnt_q                    <= next_cnt;
        end
        if (next_state == FSYNC) begin
          sync_cnt          <= '0;
          full_sync_pending <= 1'b0;
        end else if (next_state == FRAME) begin
          sync_cnt <= sync_cnt + 8'd1;
        end
      end else begin
        {TraceDoutb, TraceDouta} <= beat(shift_q[7:0], lw_q);
        shift_q                  <= shift_q >> step_cur;
        cnt_q                    <= cnt_q - 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_trace_port_tx.sv
// Testbench for trace_port_tx. A reference model expands every chosen element
// into a queue of expected output beats. The model decides each element from
// the element rules. The bench also applies a vector table, several
// hand-written sequences, a second instance with SYNC_INTERVAL=2, and a
// randomized run.
module tb_trace_port_tx;

  localparam int SI = 16;
  localparam logic [1:0] K_IDLE = 2'd0, K_FSYNC = 2'd1, K_HSYNC = 2'd2, K_FRAME = 2'd3;

  logic         clkOut = 1'b0;
  logic         rst;
  logic         Enable;
  logic [1:0]   Width;
  logic [127:0] FrameIn;
  logic         FrameValid;

  logic         ready, busy, ready2, busy2;
  logic [3:0]   douta, doutb, douta2, doutb2;
  logic [31:0]  frames, frames2;
  logic [1:0]   state, state2;

  int tests = 0;
  int fails = 0;

  // ---------------- clock ----------------
  always #5 clkOut = ~clkOut;

  trace_port_tx #(.MAX_BUS_WIDTH(4), .SYNC_INTERVAL(SI)) dut (
    .clkOut(clkOut), .rst(rst), .Enable(Enable), .Width(Width),
    .FrameIn(FrameIn), .FrameValid(FrameValid), .FrameReady(ready),
    .TraceDouta(douta), .TraceDoutb(doutb), .Busy(busy),
    .FramesSent(frames), .state_dbg(state)
  );

  trace_port_tx #(.MAX_BUS_WIDTH(4), .SYNC_INTERVAL(2)) dut2 (
    .clkOut(clkOut), .rst(rst), .Enable(Enable), .Width(Width),
    .FrameIn(FrameIn), .FrameValid(FrameValid), .FrameReady(ready2),
    .TraceDouta(douta2), .TraceDoutb(doutb2), .Busy(busy2),
    .FramesSent(frames2), .state_dbg(state2)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0] kind;
    logic       last;   // final beat of a frame
    logic [3:0] b;
    logic [3:0] a;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       cur = '0;
  logic        m_pending = 1'b1;
  int          m_cnt = 0;
  logic [31:0] m_frames = '0;
  logic        m_prev_en = 1'b0;

  function automatic int lanes(input logic [1:0] wsel);
    return (wsel == 2'b10) ? 2 : (wsel == 2'b11) ? 4 : 1;
  endfunction

  function automatic logic m_due();
    return m_pending || (Enable && !m_prev_en) || (m_cnt == SI);
  endfunction

  function automatic logic exp_ready();
    return (exp_q.size() == 0) && Enable && !m_due();
  endfunction

  task automatic push_elem(input logic [1:0] kind, input logic [127:0] data,
                           input int nbits, input int w);
    int n;
    logic [127:0] mask;
    n = nbits / (2 * w);
    mask = (128'd1 << w) - 128'd1;
    for (int c = 0; c < n; c++) begin
      beat_t e;
      e.kind = kind;
      e.last = (kind == K_FRAME) && (c == n - 1);
      e.a    = 4'((data >> (2 * w * c)) & mask);
      e.b    = 4'((data >> (2 * w * c + w)) & mask);
      exp_q.push_back(e);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      exp_q.delete();
      cur = '0; m_pending = 1'b1; m_cnt = 0; m_frames = '0; m_prev_en = 1'b0;
      return;
    end
    if (exp_q.size() == 0 && Enable) begin
      if (m_due()) begin
        push_elem(K_FSYNC, 128'h7FFF_FFFF, 32, lanes(Width));
        m_pending = 1'b0; m_cnt = 0;
      end else if (FrameValid) begin
        push_elem(K_FRAME, FrameIn, 128, lanes(Width));
        m_cnt++;
      end else begin
        push_elem(K_HSYNC, 128'h7FFF, 16, lanes(Width));
      end
    end else if (Enable && !m_prev_en) begin
      m_pending = 1'b1;
    end
    if (cur.last) m_frames++;
    m_prev_en = Enable;
    cur = (exp_q.size() != 0) ? exp_q.pop_front() : beat_t'(0);
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compares the DUT with the model for the current cycle, advances the
  // model across the coming edge, and returns at the next falling edge.
  task automatic tick();
    #1;
    check("douta", 32'(douta), 32'(cur.a));
    check("doutb", 32'(doutb), 32'(cur.b));
    check("busy", 32'(busy), 32'(cur.kind != K_IDLE));
    check("state", 32'(state), 32'(cur.kind));
    check("frames_sent", frames, m_frames);
    if (!rst) check("frame_ready", 32'(ready), 32'(exp_ready()));
    model_step();
    @(negedge clkOut);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wait_ready(input int max_cycles);
    bit found = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      #1;
      if (ready === 1'b1) begin found = 1'b1; break; end
      tick();
    end
    if (!found) begin
      tests++; fails++;
      $display("FAIL wait_ready: got no FrameReady expected one within %0d cycles", max_cycles);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       en;
    logic [1:0] width;
    logic       valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       rdy;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #1_000_000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int kinds[6];
    int len;

    rst = 1'b1; Enable = 1'b0; Width = 2'b00; FrameValid = 1'b0; FrameIn = '0;
    @(negedge clkOut);
    tick(); tick();
    #1;
    check("reset_douta", 32'(douta), 32'd0);
    check("reset_doutb", 32'(doutb), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_frames", frames, 32'd0);
    rst = 1'b0;
    @(negedge clkOut);

    // Full sync nibbles after enable, then halfword syncs every two cycles.
    vecs[0] = '{1'b1, 2'b11, 1'b0, 4'h0, 4'h0, 1'b0};
    vecs[1] = '{1'b1, 2'b11, 1'b0, 4'hF, 4'hF, 1'b0};
    vecs[2] = '{1'b1, 2'b11, 1'b0, 4'hF, 4'hF, 1'b0};
    vecs[3] = '{1'b1, 2'b11, 1'b0, 4'hF, 4'hF, 1'b0};
    vecs[4] = '{1'b1, 2'b11, 1'b0, 4'hF, 4'h7, 1'b1};
    vecs[5] = '{1'b1, 2'b11, 1'b0, 4'hF, 4'hF, 1'b0};
    vecs[6] = '{1'b1, 2'b11, 1'b0, 4'hF, 4'h7, 1'b1};
    vecs[7] = '{1'b1, 2'b11, 1'b0, 4'hF, 4'hF, 1'b0};
    vecs[8] = '{1'b1, 2'b11, 1'b0, 4'hF, 4'h7, 1'b1};
    for (int i = 0; i < 9; i++) begin
      Enable = vecs[i].en; Width = vecs[i].width; FrameValid = vecs[i].valid;
      #1;
      check("vec_douta", 32'(douta), 32'(vecs[i].a));
      check("vec_doutb", 32'(doutb), 32'(vecs[i].b));
      check("vec_ready", 32'(ready), 32'(vecs[i].rdy));
      tick();
    end

    // Frame with bytes 0x00..0x0F at 4 lanes, presented continuously.
    FrameIn = 128'h0F0E0D0C0B0A09080706050403020100;
    FrameValid = 1'b1;
    wait_ready(8);
    tick();
    #1;
    check("frame4_first_a", 32'(douta), 32'h0);
    check("frame4_first_b", 32'(doutb), 32'h0);
    tick();
    #1;
    check("frame4_second_a", 32'(douta), 32'h1);
    check("frame4_second_b", 32'(doutb), 32'h0);
    tick();
    for (int i = 0; i < 14; i++) tick();
    #1;
    check("frame4_frames_sent", frames, 32'd1);
    tick();

    // Instance with SYNC_INTERVAL=2 at 2 lanes: FSYNC, FRAME, FRAME, FSYNC, FRAME.
    do_reset();
    Enable = 1'b1; Width = 2'b10; FrameValid = 1'b1;
    FrameIn = {$urandom, $urandom, $urandom, $urandom};
    #1;
    check("si2_idle_state", 32'(state2), 32'(K_IDLE));
    check("si2_idle_ready", 32'(ready2), 32'd0);
    tick();
    kinds = '{1, 3, 3, 1, 3, 3};
    for (int e = 0; e < 5; e++) begin
      len = (kinds[e] == 1) ? 8 : 32;
      for (int k = 0; k < len; k++) begin
        #1;
        check("si2_state", 32'(state2), 32'(kinds[e]));
        check("si2_ready", 32'(ready2), 32'((k == len - 1) && (kinds[e + 1] == 3)));
        tick();
      end
    end

    // Single frame 0x..01 at 1 lane.
    FrameValid = 1'b0;
    do_reset();
    Enable = 1'b1; Width = 2'b01;
    wait_ready(40);
    FrameIn = 128'h1; FrameValid = 1'b1;
    tick();
    FrameValid = 1'b0;
    for (int k = 0; k < 64; k++) begin
      #1;
      if (k == 0) begin
        check("w1_first_a", 32'(douta), 32'h1);
        check("w1_first_b", 32'(doutb), 32'h0);
      end
      check("w1_upper_lanes", 32'({douta[3:1], doutb[3:1]}), 32'h0);
      check("w1_state", 32'(state), 32'(K_FRAME));
      tick();
    end
    #1;
    check("w1_after_state", 32'(state), 32'(K_HSYNC));
    check("w1_frames_sent", frames, 32'd1);
    tick();

    // Width change during a 4-lane frame takes effect at the next element.
    Width = 2'b11;
    wait_ready(20);
    FrameIn = {$urandom, $urandom, $urandom, $urandom}; FrameValid = 1'b1;
    tick();
    FrameValid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      #1;
      if (k == 5) Width = 2'b01;
      check("wchg_frame_state", 32'(state), 32'(K_FRAME));
      tick();
    end
    for (int k = 0; k < 8; k++) begin
      #1;
      check("wchg_hsync_state", 32'(state), 32'(K_HSYNC));
      check("wchg_hsync_b", 32'(doutb), (k == 7) ? 32'h0 : 32'h1);
      tick();
    end

    // Enable dropped mid-frame, then reset during a later full sync.
    Width = 2'b11;
    wait_ready(20);
    FrameIn = {$urandom, $urandom, $urandom, $urandom}; FrameValid = 1'b1;
    tick();
    FrameValid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      #1;
      if (k == 3) Enable = 1'b0;
      tick();
    end
    #1;
    check("drop_idle_busy", 32'(busy), 32'd0);
    check("drop_idle_out", 32'({douta, doutb}), 32'd0);
    tick(); tick(); tick();
    Enable = 1'b1;
    tick(); tick();
    rst = 1'b1; Enable = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check("rst_mid_out", 32'({douta, doutb}), 32'd0);
    check("rst_mid_frames", frames, 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    tick();
    Enable = 1'b1;
    tick();
    #1;
    check("reenable_state", 32'(state), 32'(K_FSYNC));
    check("reenable_a", 32'(douta), 32'hF);
    tick();

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      Enable = ($urandom_range(0, 29) != 0);
      if ($urandom_range(0, 9) == 0) Width = 2'($urandom_range(0, 3));
      FrameValid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) FrameIn = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
